// File: rtl/muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl_pkg
// Description : Shared constants, M-op encodings and state type for the
//               RV32M multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_ctrl_pkg;

    localparam int XLEN     = 32;
    localparam int MDOP_WID = 3;
    localparam int CNT_WID  = 5;

    // funct3 encodings of the M extension, also used by the decoder
    localparam logic [MDOP_WID-1:0] MD_MUL    = 3'd0;
    localparam logic [MDOP_WID-1:0] MD_MULH   = 3'd1;
    localparam logic [MDOP_WID-1:0] MD_MULHSU = 3'd2;
    localparam logic [MDOP_WID-1:0] MD_MULHU  = 3'd3;
    localparam logic [MDOP_WID-1:0] MD_DIV    = 3'd4;
    localparam logic [MDOP_WID-1:0] MD_DIVU   = 3'd5;
    localparam logic [MDOP_WID-1:0] MD_REM    = 3'd6;
    localparam logic [MDOP_WID-1:0] MD_REMU   = 3'd7;

    // 32 iterations: the counter starts at 31 and the last step runs at 0
    localparam logic [CNT_WID-1:0] ITER_LAST = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // rs1 is treated as signed for every op except the unsigned variants
    function automatic logic src1_is_signed(input logic [MDOP_WID-1:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is signed only for the fully-signed ops (MULHSU treats it unsigned)
    function automatic logic src2_is_signed(input logic [MDOP_WID-1:0] op);
        return (op == MD_MUL) || (op == MD_MULH) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl_if
// Description : EX-stage <-> multiply/divide sequencer handshake bundle.
//               master = EX stage, slave = muldiv_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_ctrl_if;
    import muldiv_ctrl_pkg::*;

    logic                req;
    logic [MDOP_WID-1:0] op;
    logic [XLEN-1:0]     src1;
    logic [XLEN-1:0]     src2;
    logic                flush;
    logic                stall;
    logic                done;
    logic [XLEN-1:0]     result;

    modport master (
        output req, op, src1, src2, flush,
        input  stall, done, result
    );

    modport slave (
        input  req, op, src1, src2, flush,
        output stall, done, result
    );

endinterface
`default_nettype wire

// File: rtl/muldiv_ctrl_core.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_core
// Description : Iterative unsigned datapath. Multiply is a right-shifting
//               shift-add (hi:lo holds the partial product, lo starts as the
//               multiplier); divide is a restoring divide (hi is the 33-bit
//               remainder, lo shifts the dividend out and the quotient in).
//               Next-state values are exported so the controller can fix up
//               and capture the result on the final step.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_core
    import muldiv_ctrl_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            load_i,
    input  wire logic            step_i,
    input  wire logic            is_div_i,
    input  wire logic [XLEN-1:0] a_i,
    input  wire logic [XLEN-1:0] b_i,
    output logic      [XLEN-1:0] hi_nxt_o,
    output logic      [XLEN-1:0] lo_nxt_o
);

    logic [XLEN:0]   hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] b_q;

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN+1:0] div_diff;
    logic            div_ok;

    // one iteration of either algorithm, or a fresh load of the operands
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        // hi_q[XLEN] is always zero in multiply mode, so the full-width add is safe
        mul_sum   = hi_q + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
        div_ok    = ~div_diff[XLEN+1];

        if (load_i) begin
            hi_d = '0;
            lo_d = a_i;
        end else if (step_i) begin
            if (is_div_i) begin
                hi_d = div_ok ? div_diff[XLEN:0] : div_shift;
                lo_d = {lo_q[XLEN-2:0], div_ok};
            end else begin
                hi_d = {1'b0, mul_sum[XLEN:1]};
                lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
            end
        end
    end

    // accumulator and operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            if (load_i) begin
                b_q <= b_i;
            end
        end
    end

    assign hi_nxt_o = hi_d[XLEN-1:0];
    assign lo_nxt_o = lo_d;

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : RV32M multiply/divide sequencer for the EX stage. Accepts one
//               M-op, stalls the pipeline for 32 iterations, applies the sign
//               fix-up and returns the result with a one-cycle done pulse.
//               Divide-by-zero and signed overflow finish without iterating.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  wire logic    clk,
    input  wire logic    rst_n,
    muldiv_ctrl_if.slave md
);

    md_state_e           state_q, state_d;
    logic [CNT_WID-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [MDOP_WID-1:0] op_q;
    logic                neg_q;     // product/quotient negation
    logic                rneg_q;    // remainder takes the sign of rs1

    logic                accept;
    logic                s1_neg, s2_neg;
    logic [XLEN-1:0]     mag1, mag2;
    logic                div_zero, div_ovf, special;
    logic [XLEN-1:0]     special_res;
    logic                step;
    logic [XLEN-1:0]     hi_nxt, lo_nxt;
    logic [2*XLEN-1:0]   prod, prod_fix;
    logic [XLEN-1:0]     quot_fix, rem_fix, final_res;
    logic                stall, done;

    // accept decode, operand magnitudes and the non-iterating special cases
    always_comb begin
        accept   = (state_q == ST_IDLE) && md.req && !md.flush;
        s1_neg   = src1_is_signed(md.op) && md.src1[XLEN-1];
        s2_neg   = src2_is_signed(md.op) && md.src2[XLEN-1];
        mag1     = s1_neg ? (~md.src1 + 1'b1) : md.src1;
        mag2     = s2_neg ? (~md.src2 + 1'b1) : md.src2;
        div_zero = md.op[2] && (md.src2 == '0);
        div_ovf  = ((md.op == MD_DIV) || (md.op == MD_REM)) &&
                   (md.src1 == 32'h8000_0000) && (md.src2 == 32'hFFFF_FFFF);
        special  = div_zero || div_ovf;
        // op[1] separates REM/REMU from DIV/DIVU
        if (div_zero) begin
            special_res = md.op[1] ? md.src1 : '1;
        end else begin
            special_res = md.op[1] ? '0 : 32'h8000_0000;
        end
    end

    assign step = (state_q == ST_BUSY) && !md.flush;

    muldiv_core u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (accept),
        .step_i   (step),
        .is_div_i (op_q[2]),
        .a_i      (mag1),
        .b_i      (mag2),
        .hi_nxt_o (hi_nxt),
        .lo_nxt_o (lo_nxt)
    );

    // sign fix-up and result selection on the values the final step produces
    always_comb begin
        prod     = {hi_nxt, lo_nxt};
        prod_fix = neg_q  ? (~prod + 1'b1)   : prod;
        quot_fix = neg_q  ? (~lo_nxt + 1'b1) : lo_nxt;
        rem_fix  = rneg_q ? (~hi_nxt + 1'b1) : hi_nxt;
        case (op_q)
            MD_MUL:                        final_res = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               final_res = quot_fix;
            default:                       final_res = rem_fix;
        endcase
    end

    // next-state, counter and result logic; flush always returns to IDLE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        stall    = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall = md.req && !md.flush;
                if (accept) begin
                    cnt_d = ITER_LAST;
                    if (special) begin
                        state_d  = ST_DONE;
                        result_d = special_res;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                stall = !md.flush;
                if (md.flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d  = ST_DONE;
                    result_d = final_res;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state register, counter and result hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // op and sign flags captured at accept so BUSY ignores later operand changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= MD_MUL;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else if (accept) begin
            op_q   <= md.op;
            neg_q  <= s1_neg ^ s2_neg;
            rneg_q <= s1_neg;
        end
    end

    // stall is gated by reset so it drops the instant reset asserts
    assign md.stall  = rst_n & stall;
    assign md.done   = done;
    assign md.result = result_q;

endmodule
`default_nettype wire
